bus_target: RTL and testbench

BUS_TARGET -- requirements
Module: bus_target

---
 rtl/bus_pkg.sv | 14 +
 rtl/bit_sync.sv | 23 ++
 rtl/bus_target.sv | 152 +++++++++++++++
 tb/tb_bus_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus phase codes and target FSM encoding; CPU-side logic imports the same phase codes.
package bus_pkg;

  localparam logic [1:0] PH_ADDR_LO = 2'b00;
  localparam logic [1:0] PH_ADDR_HI = 2'b01;
  localparam logic [1:0] PH_READ    = 2'b10;
  localparam logic [1:0] PH_WRITE   = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_MEM     = 2'b01;
  localparam logic [1:0] ST_ACK     = 2'b10;
  localparam logic [1:0] ST_RELEASE = 2'b11;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by async active-low reset.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* keep = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bus_target.sv
// Four-phase CPU bus target bridging to a simple strobe/ready memory port.
module bus_target
  import bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic [1:0]  bus_state,
  input  logic [7:0]  bus_data_in,
  output logic        bus_ack,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        proto_err
);

  logic        req_s;
  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        abort_q, abort_d;
  logic        ack_q, ack_d;
  logic        oe_q, oe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_req),
    .q     (req_s)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          abort_d = 1'b0;
          case (bus_state)
            PH_ADDR_LO: begin
              addr_d[7:0] = bus_data_in;
              ack_d       = 1'b1;
              state_d     = ST_ACK;
            end
            PH_ADDR_HI: begin
              addr_d[15:8] = bus_data_in;
              ack_d        = 1'b1;
              state_d      = ST_ACK;
            end
            PH_READ: begin
              rd_d    = 1'b1;
              state_d = ST_MEM;
            end
            default: begin
              wdata_d = bus_data_in;
              wr_d    = 1'b1;
              state_d = ST_MEM;
            end
          endcase
        end
      end
      ST_MEM: begin
        // A request withdrawn mid-access is remembered so the CPU never sees a late ack.
        if (!req_s) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
        if (mem_ready) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (abort_d) begin
            state_d = ST_RELEASE;
          end else begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
            if (rd_q) begin
              rdata_d = mem_rdata;
              oe_d    = 1'b1;
            end
          end
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_ack      = ack_q;
  assign bus_data_oe  = oe_q;
  assign bus_data_out = rdata_q;
  assign mem_addr     = addr_q;
  assign mem_read     = rd_q;
  assign mem_write    = wr_q;
  assign mem_wdata    = wdata_q;
  assign proto_err    = err_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: address phases, read/write, aborted access, reset mid-transfer.
module tb_bus_target;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic [1:0]  bus_state = PH_ADDR_LO;
  logic [7:0]  bus_data_in = 8'h00;
  logic        bus_ack;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  // Activity counters sampled on the falling edge, away from the bench's own sampling points.
  int ack_rise = 0;
  int wr_rise = 0;
  int rd_rise = 0;
  int both_hi = 0;
  logic ack_p = 1'b0, wr_p = 1'b0, rd_p = 1'b0;

  always #5 clk = ~clk;

  bus_target #(
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_req      (bus_req),
    .bus_state    (bus_state),
    .bus_data_in  (bus_data_in),
    .bus_ack      (bus_ack),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .proto_err    (proto_err)
  );

  always @(negedge clk) begin
    if (bus_ack && !ack_p) ack_rise++;
    if (mem_write && !wr_p) wr_rise++;
    if (mem_read && !rd_p) rd_rise++;
    if (mem_read && mem_write) both_hi++;
    ack_p = bus_ack;
    wr_p  = mem_write;
    rd_p  = mem_read;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise bus_req and count edges until bus_ack rises (99 on timeout).
  task automatic raise_req(output int lat);
    @(negedge clk);
    bus_req = 1'b1;
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drop_req(output int lat);
    @(negedge clk);
    bus_req = 1'b0;
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (!bus_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  // Wait (bounded) until the given strobe is high, sampled #1 after an edge.
  task automatic wait_strobe(input bit is_write, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (is_write ? mem_write : mem_read) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int  lat;
  int  n;
  int  snap_ack, snap_wr, snap_rd;
  bit  seen;

  initial begin
    #1;
    check("reset_ack", bus_ack, 0);
    check("reset_strobes", {mem_read, mem_write}, 0);
    check("reset_addr", mem_addr, 16'h0000);
    check("reset_oe_data", {bus_data_oe, bus_data_out}, 0);
    check("reset_err", proto_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Address phases
    snap_wr = wr_rise; snap_rd = rd_rise;
    bus_state = PH_ADDR_LO; bus_data_in = 8'h34;
    raise_req(lat);
    check("addr_lo_ack_lat", lat, 3);
    drop_req(lat);
    check("addr_lo_rel_lat", lat, 3);
    bus_state = PH_ADDR_HI; bus_data_in = 8'h12;
    raise_req(lat);
    check("addr_hi_ack_lat", lat, 3);
    drop_req(lat);
    check("addr_hi_rel_lat", lat, 3);
    check("addr_value", mem_addr, 16'h1234);
    check("addr_no_strobe", (wr_rise - snap_wr) + (rd_rise - snap_rd), 0);

    // READ with memory ready after 4 cycles
    mem_rdata = 8'hA5; mem_ready = 1'b0;
    bus_state = PH_READ; bus_data_in = 8'hFF;
    @(negedge clk);
    bus_req = 1'b1;
    wait_strobe(1'b0, seen);
    check("read_strobe_seen", seen, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (n == 4) mem_ready = 1'b1;
      @(posedge clk);
      #1;
      if (mem_read) n++;
      else break;
    end
    mem_ready = 1'b0;
    check("read_strobe_cycles", n, 4);
    check("read_ack", bus_ack, 1);
    check("read_oe", bus_data_oe, 1);
    check("read_data", bus_data_out, 8'hA5);
    drop_req(lat);
    check("read_rel_lat", lat, 3);
    check("read_oe_off", bus_data_oe, 0);

    // WRITE with memory already ready
    snap_wr = wr_rise;
    mem_ready = 1'b1;
    bus_state = PH_WRITE; bus_data_in = 8'h5A;
    raise_req(lat);
    check("write_ack_lat", lat, 4);
    check("write_wdata", mem_wdata, 8'h5A);
    check("write_addr", mem_addr, 16'h1234);
    check("write_strobe_off", mem_write, 0);
    check("write_err", proto_err, 0);
    drop_req(lat);
    check("write_rel_lat", lat, 3);
    check("write_one_strobe", wr_rise - snap_wr, 1);
    mem_ready = 1'b0;

    // READ aborted while in MEM
    snap_ack = ack_rise;
    mem_rdata = 8'h99;
    bus_state = PH_READ;
    @(negedge clk);
    bus_req = 1'b1;
    wait_strobe(1'b0, seen);
    check("abort_strobe_seen", seen, 1);
    @(negedge clk);
    bus_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_err", proto_err, 1);
    check("abort_read_held", mem_read, 1);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("abort_read_done", mem_read, 0);
    mem_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_ack", ack_rise - snap_ack, 0);
    check("abort_no_oe", bus_data_oe, 0);

    // Next READ succeeds, error stays sticky
    mem_rdata = 8'h3C; mem_ready = 1'b1;
    raise_req(lat);
    check("read2_ack_lat", lat, 4);
    check("read2_data", bus_data_out, 8'h3C);
    check("read2_err_sticky", proto_err, 1);
    drop_req(lat);
    mem_ready = 1'b0;

    // Bus noise with no request
    snap_ack = ack_rise; snap_wr = wr_rise; snap_rd = rd_rise;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_state   = 2'($urandom_range(0, 3));
      bus_data_in = 8'($urandom_range(0, 255));
      mem_ready   = 1'($urandom_range(0, 1));
    end
    repeat (4) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("noise_no_ack", ack_rise - snap_ack, 0);
    check("noise_no_strobe", (wr_rise - snap_wr) + (rd_rise - snap_rd), 0);
    check("noise_addr", mem_addr, 16'h1234);

    // Reset during MEM of a WRITE with bus_req held high
    bus_state = PH_WRITE; bus_data_in = 8'h77;
    @(negedge clk);
    bus_req = 1'b1;
    wait_strobe(1'b1, seen);
    check("rst_write_seen", seen, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_ack", bus_ack, 0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_err", proto_err, 0);
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    snap_wr = wr_rise;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (mem_write) begin
        lat = i;
        break;
      end
    end
    check("post_rst_write_lat", lat, 3);
    check("post_rst_addr", mem_addr, 16'h0000);
    check("post_rst_wdata", mem_wdata, 8'h77);
    @(posedge clk);
    #1;
    check("post_rst_ack", bus_ack, 1);
    drop_req(lat);
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_one_access", wr_rise - snap_wr, 1);
    check("never_both_strobes", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
